// File: rtl/ahb2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb2_pkg                                                |
// | Description : Shared AHB2 (AHB-Lite) encodings used by the master and |
// |               by the slave memories/peripherals.                      |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package ahb2_pkg;

   // Transfer type encodings driven on htrans.
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   // Slave response encodings on hresp.
   localparam logic       HRESP_OKAY      = 1'b0;
   localparam logic       HRESP_ERROR     = 1'b1;

   // Fixed transfer attributes: 32-bit single beats, privileged data access.
   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage
`default_nettype wire

// File: rtl/ahb2_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb2_master                                             |
// | Description : AHB2 (AHB-Lite) master turning a valid/ready command    |
// |               stream into pipelined single-beat 32-bit transfers,     |
// |               with wait-state and two-cycle ERROR/replay handling.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module ahb2_master
   import ahb2_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // command stream
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   // response stream
   output logic                  rsp_valid,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  busy,
   // AHB2 master interface
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [1:0]            htrans,
   output logic                  hwrite,
   output logic [2:0]            hsize,
   output logic [2:0]            hburst,
   output logic [3:0]            hprot,
   output logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hready,
   input  logic                  hresp
);

   // Address-phase stage: the command currently presented on the bus.
   logic                  r_ap_valid;
   logic                  r_ap_write;
   logic [ADDR_WIDTH-1:0] r_ap_addr;
   logic [DATA_WIDTH-1:0] r_ap_wdata;

   // Data-phase stage: the command whose response is awaited.
   logic                  r_dp_valid;
   logic                  r_dp_write;

   // Set in the first ERROR cycle; forces IDLE and stalls the pipe for one cycle.
   logic                  r_squash;

   logic [DATA_WIDTH-1:0] r_hwdata;
   logic                  r_rsp_valid;
   logic                  r_rsp_write;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;

   logic                  w_advance;
   logic                  w_accept;
   logic                  w_dp_done;
   logic                  w_err_first;
   logic                  w_addr_lsb_unused;

   // The pipe moves only on a completed bus cycle that is not being squashed.
   assign w_advance   = hready & ~r_squash;
   assign w_accept    = req_valid & w_advance;
   assign w_dp_done   = r_dp_valid & hready;
   assign w_err_first = r_dp_valid & ~hready & (hresp == HRESP_ERROR);

   // Byte-lane bits of the request address are discarded (word transfers only).
   assign w_addr_lsb_unused = ^req_addr[1:0];

   // Pipeline registers: load a new command and shift address phase into data phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ap_valid <= 1'b0;
         r_ap_write <= 1'b0;
         r_ap_addr  <= '0;
         r_ap_wdata <= '0;
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
         r_hwdata   <= '0;
      end else if (w_advance) begin
         r_dp_valid <= r_ap_valid;
         r_dp_write <= r_ap_write;
         if (r_ap_valid) begin
            r_hwdata <= r_ap_wdata;
         end
         r_ap_valid <= w_accept;
         if (w_accept) begin
            r_ap_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            r_ap_write <= req_write;
            r_ap_wdata <= req_wdata;
         end
      end else if (r_squash && hready) begin
         // Second ERROR cycle: retire the failed transfer, keep the queued one.
         r_dp_valid <= 1'b0;
      end
   end

   // Squash flag spans exactly the second cycle of a two-cycle ERROR response.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_squash <= 1'b0;
      end else if (w_err_first) begin
         r_squash <= 1'b1;
      end else if (hready) begin
         r_squash <= 1'b0;
      end
   end

   // Response capture: one pulse per completed data phase, payload held until the next.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= w_dp_done;
         if (w_dp_done) begin
            r_rsp_write <= r_dp_write;
            r_rsp_err   <= (hresp == HRESP_ERROR);
            r_rsp_rdata <= (!r_dp_write && (hresp == HRESP_OKAY)) ? hrdata : '0;
         end
      end
   end

   assign req_ready = w_advance;
   assign busy      = r_ap_valid | r_dp_valid;

   assign htrans    = (r_ap_valid && !r_squash) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr     = r_ap_addr;
   assign hwrite    = r_ap_write;
   assign hwdata    = r_hwdata;
   assign hsize     = HSIZE_WORD;
   assign hburst    = HBURST_SINGLE;
   assign hprot     = HPROT_DATA_PRIV;

   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
